// File: rtl/dma_ch_scheduler_if.sv
// Channel-side and FIFO-side signals of the DMA channel scheduler.
// master = scheduler, slave = channel engines plus FIFO write side.
interface dma_ch_scheduler_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 2
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_last;
    logic                 fifo_full;
    logic [NUM_CH-1:0]    grant;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 fifo_w_en;
    logic [NUM_CH-1:0]    ch_done;
    logic [CNT_WIDTH-1:0] beat_cnt;

    modport master (
        input  ch_req, ch_last, fifo_full,
        output grant, grant_id, busy, fifo_w_en, ch_done, beat_cnt
    );

    modport slave (
        output ch_req, ch_last, fifo_full,
        input  grant, grant_id, busy, fifo_w_en, ch_done, beat_cnt
    );
endinterface

// File: rtl/dma_ch_scheduler.sv
// Grants one DMA channel at a time and paces its burst into the shared staging FIFO.
// Define DMA_SCHED_FIXED_PRIO_EN for fixed priority (ch0 highest) instead of round-robin.
module dma_ch_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_ch_scheduler_if.master   bus,
    output logic [1:0]           o_state,
    output logic [1:0]           o_rr_ptr
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFER    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]           r_state;
    logic [NUM_CH-1:0]    r_grant;
    logic [1:0]           r_grant_id;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [NUM_CH-1:0]    r_ch_done;
    logic [1:0]           r_rr_ptr;

    logic       w_xfer;
    logic       w_req_sel;
    logic       w_last_sel;
    logic       w_found;
    logic [1:0] w_pick_id;
    logic       w_beat;
    logic       w_end;
    logic       w_abort;

    // Requester selection for the next grant.
    always_comb begin
        w_pick_id = 2'd0;
        w_found   = 1'b0;
`ifdef DMA_SCHED_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_req[i]) begin
                w_found   = 1'b1;
                w_pick_id = 2'(i);
            end
        end
`else
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && bus.ch_req[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                w_found   = 1'b1;
                w_pick_id = 2'((int'(r_rr_ptr) + k) % NUM_CH);
            end
        end
`endif
    end

    always_comb begin
        w_req_sel  = 1'b0;
        w_last_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant_id == 2'(i)) begin
                w_req_sel  = bus.ch_req[i];
                w_last_sel = bus.ch_last[i];
            end
        end
    end

    // Handshake: fifo_w_en is the valid of the granted channel's beat and
    // !fifo_full is ready; a beat transfers only in a cycle where both are high.
    assign w_xfer  = (r_state == S_XFER);
    assign w_beat  = w_xfer & ~bus.fifo_full & w_req_sel;
    assign w_end   = w_beat & ((r_beat_cnt == CNT_WIDTH'(BURST_LEN - 1)) | w_last_sel);
    assign w_abort = w_xfer & ~w_req_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= 2'd0;
            r_beat_cnt <= '0;
            r_ch_done  <= '0;
            r_rr_ptr   <= 2'd0;
        end else begin
            r_ch_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_XFER;
                        r_grant    <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick_id;
                        r_grant_id <= w_pick_id;
                        r_beat_cnt <= '0;
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                    end
                    // Both a normal end and an abort produce the same single done pulse.
                    if (w_end || w_abort) begin
                        r_state   <= S_RELEASE;
                        r_grant   <= '0;
                        r_ch_done <= r_grant;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
`ifndef DMA_SCHED_FIXED_PRIO_EN
                    r_rr_ptr <= (r_grant_id == 2'(NUM_CH - 1)) ? 2'd0 : r_grant_id + 2'd1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = w_xfer;
    assign bus.fifo_w_en = w_beat;
    assign bus.ch_done   = r_ch_done;
    assign bus.beat_cnt  = r_beat_cnt;
    assign o_state       = r_state;
    assign o_rr_ptr      = r_rr_ptr;
endmodule

// File: tb/tb_dma_ch_scheduler.sv
// Directed self-checking bench for dma_ch_scheduler (round-robin default, fixed priority when
// DMA_SCHED_FIXED_PRIO_EN is defined).
module tb_dma_ch_scheduler;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_XFER    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state;
    logic [1:0] rr_ptr;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];

    dma_ch_scheduler_if #(.NUM_CH(4), .CNT_WIDTH(2)) bus ();

    dma_ch_scheduler #(.NUM_CH(4), .BURST_LEN(4), .CNT_WIDTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .o_state  (state),
        .o_rr_ptr (rr_ptr)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Called in the first XFER cycle; runs n full beats, checks RELEASE, ends in IDLE.
    task automatic burst(input logic [3:0] g, input int n);
        for (int b = 0; b < n; b++) begin
            check_eq("xfer_grant", bus.grant, g);
            check_eq("xfer_grant_id", bus.grant_id, id_of(g));
            check_eq("xfer_busy", bus.busy, 1'b1);
            check_eq("xfer_w_en", bus.fifo_w_en, 1'b1);
            check_eq("xfer_beat_cnt", bus.beat_cnt, b[1:0]);
            check_eq("xfer_done_low", bus.ch_done, 4'b0000);
            tick();
        end
        check_eq("rel_state", state, S_RELEASE);
        check_eq("rel_grant", bus.grant, 4'b0000);
        check_eq("rel_busy", bus.busy, 1'b0);
        check_eq("rel_w_en", bus.fifo_w_en, 1'b0);
        check_eq("rel_done", bus.ch_done, g);
        tick();
        check_eq("idle_state", state, S_IDLE);
        check_eq("idle_done", bus.ch_done, 4'b0000);
        check_eq("idle_w_en", bus.fifo_w_en, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.ch_req    = 4'b0000;
        bus.ch_last   = 4'b0000;
        bus.fifo_full = 1'b0;
        repeat (2) tick();
        check_eq("rst_grant", bus.grant, 4'b0000);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_state", state, S_IDLE);
        check_eq("rst_rr_ptr", rr_ptr, 2'd0);
        check_eq("rst_beat_cnt", bus.beat_cnt, 2'd0);
        check_eq("rst_done", bus.ch_done, 4'b0000);
        rst_n = 1'b1;
        tick();

        // Arbitration sequence with requests held continuously.
`ifdef DMA_SCHED_FIXED_PRIO_EN
        exp_q = '{4'b0001, 4'b0001, 4'b0001};
        bus.ch_req = 4'b1001;
`else
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.ch_req = 4'b1111;
`endif
        #1;
        check_eq("pre_grant_w_en", bus.fifo_w_en, 1'b0);
        tick();
        while (exp_q.size() > 0) begin
            logic [3:0] g;
            g = exp_q.pop_front();
            burst(g, 4);
            if (exp_q.size() == 0) bus.ch_req = 4'b0000;
            tick();
        end
        check_eq("arb_end_idle", state, S_IDLE);
        check_eq("arb_end_busy", bus.busy, 1'b0);

        // Single channel, grant latency of one cycle.
        bus.ch_req = 4'b0001;
        tick();
        burst(4'b0001, 4);
        bus.ch_req = 4'b0000;
        tick();
        check_eq("single_stay_idle", state, S_IDLE);

        // Backpressure after beat 2 for three cycles.
        bus.ch_req = 4'b0010;
        tick();
        check_eq("bp_grant", bus.grant, 4'b0010);
        check_eq("bp_cnt0", bus.beat_cnt, 2'd0);
        tick();
        check_eq("bp_cnt1", bus.beat_cnt, 2'd1);
        tick();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("bp_stall_w_en", bus.fifo_w_en, 1'b0);
            check_eq("bp_stall_cnt", bus.beat_cnt, 2'd2);
            check_eq("bp_stall_grant", bus.grant, 4'b0010);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        check_eq("bp_resume_w_en", bus.fifo_w_en, 1'b1);
        check_eq("bp_resume_cnt", bus.beat_cnt, 2'd2);
        tick();
        check_eq("bp_cnt3", bus.beat_cnt, 2'd3);
        check_eq("bp_cnt3_w_en", bus.fifo_w_en, 1'b1);
        tick();
        check_eq("bp_rel_state", state, S_RELEASE);
        check_eq("bp_done", bus.ch_done, 4'b0010);
        bus.ch_req = 4'b0000;
        tick();

        // Early end via ch_last on beat 1.
        bus.ch_req = 4'b0100;
        tick();
        check_eq("last_grant", bus.grant, 4'b0100);
        tick();
        bus.ch_last = 4'b0100;
        #1;
        check_eq("last_beat1_w_en", bus.fifo_w_en, 1'b1);
        check_eq("last_beat1_cnt", bus.beat_cnt, 2'd1);
        tick();
        bus.ch_last = 4'b0000;
        check_eq("last_rel_state", state, S_RELEASE);
        check_eq("last_done", bus.ch_done, 4'b0100);
        check_eq("last_cnt", bus.beat_cnt, 2'd2);
        bus.ch_req = 4'b0000;
        tick();

        // Abort: ch3 drops its request after one beat.
        bus.ch_req = 4'b1000;
        tick();
        check_eq("abort_grant", bus.grant, 4'b1000);
        tick();
        bus.ch_req = 4'b0000;
        #1;
        check_eq("abort_w_en", bus.fifo_w_en, 1'b0);
        tick();
        check_eq("abort_rel_state", state, S_RELEASE);
        check_eq("abort_done", bus.ch_done, 4'b1000);
        check_eq("abort_cnt", bus.beat_cnt, 2'd1);
        tick();
        check_eq("abort_idle", state, S_IDLE);
        check_eq("abort_rr_ptr", rr_ptr, 2'd0);

        // Reset in the middle of a ch1 burst.
        bus.ch_req = 4'b0010;
        tick();
        check_eq("mid_grant", bus.grant, 4'b0010);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_grant", bus.grant, 4'b0000);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_w_en", bus.fifo_w_en, 1'b0);
        check_eq("mid_rst_done", bus.ch_done, 4'b0000);
        bus.ch_req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_state", state, S_IDLE);
        check_eq("post_rst_rr_ptr", rr_ptr, 2'd0);
        check_eq("post_rst_done", bus.ch_done, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dma_ch_scheduler.md
Name: dma_ch_scheduler

Overview:
Round-robin scheduler that shares the single DMA staging FIFO (DATA_WIDTH=32, depth 4) among the four DMA channels. It grants one channel at a time and paces that channel's burst into the FIFO write port, honouring FIFO full. It also signals burst completion back to the channel engines. It sits between the channel register/engine blocks and the shared dma_fifo write side.

Parameters:
NUM_CH, 4, number of requesting channels (grant_id width fixed at 2 bits; NUM_CH <= 4)
BURST_LEN, 4, max beats per grant; equals FIFO depth
CNT_WIDTH, 2, beat counter width; must satisfy 2^CNT_WIDTH >= BURST_LEN

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ch_req  input  NUM_CH  per-channel transfer request, level, held while channel has data
ch_last  input  NUM_CH  per-channel "current beat is last of transfer", sampled only for the granted channel on an accepted beat
fifo_full  input  1  FIFO full flag
grant  output  NUM_CH  one-hot grant, registered
grant_id  output  2  binary index of granted channel, valid when busy=1
busy  output  1  high in XFER
fifo_w_en  output  1  FIFO write strobe for granted channel's beat (combinational: XFER & !fifo_full & ch_req[grant_id])
ch_done  output  NUM_CH  one-cycle pulse per channel at burst end
beat_cnt  output  CNT_WIDTH  beats accepted in current burst

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, grant_id=0, busy=0, ch_done=0, beat_cnt=0, rr_ptr=0. fifo_w_en=0 follows.
- States: IDLE, XFER, RELEASE.
- IDLE: if |ch_req, pick the first requester scanning rr_ptr, rr_ptr+1, ... (mod NUM_CH). Next edge: state=XFER, grant/grant_id set, beat_cnt=0. Grant latency: 1 cycle after ch_req is sampled high.
- XFER: beat accepted when fifo_w_en=1; beat_cnt increments on each accepted beat.
- fifo_full=1 stalls: no write, no count, grant held indefinitely.
- Burst end on an accepted beat if beat_cnt==BURST_LEN-1 OR ch_last[grant_id]=1 -> RELEASE.
- Abort: ch_req[grant_id]=0 in XFER -> RELEASE next edge, no beat that cycle. Same ch_done pulse; beat_cnt reports partial count in RELEASE.
- RELEASE (exactly 1 cycle): grant=0, busy=0, ch_done[grant_id]=1, rr_ptr=grant_id+1 mod NUM_CH; next state IDLE. Minimum gap between bursts is 2 cycles (RELEASE + IDLE).
- Requests arriving or dropping for non-granted channels have no effect until IDLE.
- Simultaneous ch_last and beat_cnt==BURST_LEN-1: single end, single ch_done.
- grant is never multi-hot. fifo_w_en is never high outside XFER.
- Reset mid-burst: immediate return to reset values; partial burst is discarded with no ch_done. FIFO contents are the FIFO's own concern.

Optional Feature:
DMA_SCHED_FIXED_PRIO_EN
- Defined: rr_ptr unused; IDLE always picks the lowest-index requester (ch0 highest priority).
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst_n=0 mid-XFER with grant=4'b0010 -> grant=0, busy=0, fifo_w_en=0 immediately; after release, state IDLE, rr_ptr=0.
- Single channel: ch_req=4'b0001, fifo_full=0 -> grant=0001 one cycle later; 4 consecutive fifo_w_en pulses, beat_cnt 0..3; then ch_done=0001 for 1 cycle, grant=0.
- Round-robin fairness: ch_req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each burst 4 beats, 2-cycle gap between bursts.
- Backpressure: fifo_full=1 for 3 cycles after beat 2 -> fifo_w_en=0 and beat_cnt stays 2 for those cycles; burst resumes and ends at 4 beats.
- Early end/abort: ch_last[2]=1 on beat 1 -> ch_done=0100 after 2 beats. ch_req[3] dropped after 1 beat -> RELEASE, ch_done=1000, beat_cnt=1.
- Fixed priority (DMA_SCHED_FIXED_PRIO_EN): ch_req=4'b1001 held -> ch0 granted every burst, ch3 never granted.
